// File: rtl/ltu_pkg.sv
// Shared constants and helpers for the LTU clock-enable divider.
package ltu_pkg;

  localparam int LTU_DIVSEL_W = 2;
  localparam int LTU_CNT_W    = 3;

  // Terminal count of the period counter for a divide setting: N-1 with N = 2^s.
  function automatic logic [LTU_CNT_W-1:0] ltu_term_cnt(input logic [LTU_DIVSEL_W-1:0] s);
    logic [LTU_CNT_W-1:0] tc;
    tc = '0;
    case (s)
      2'd0: tc = 3'd0;
      2'd1: tc = 3'd1;
      2'd2: tc = 3'd3;
      2'd3: tc = 3'd7;
      default: tc = 3'd0;
    endcase
    return tc;
  endfunction

endpackage

// File: rtl/ltu_clk_div.sv
// Programmable clock-enable divider: one-cycle ltu_tick every 1, 2, 4 or 8
// clk cycles. A new setting is only adopted on the closing tick edge of the
// current period, so periods are never truncated or stretched.
module ltu_clk_div
  import ltu_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic [LTU_DIVSEL_W-1:0] LTUCLKDIVSET,
  output logic [LTU_DIVSEL_W-1:0] LTUCLKDIVGET,
  output logic                    ltu_tick
);

  logic [LTU_DIVSEL_W-1:0] act;
  logic [LTU_CNT_W-1:0]    cnt;
  logic                    at_tc;

  // Terminal-count decode from registers only; SET has no path to the tick.
  always_comb begin
    at_tc = (cnt == ltu_term_cnt(act));
  end

  // Period counter and active setting move together, which keeps cnt <= N-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act <= '0;
      cnt <= '0;
    end else if (at_tc) begin
      act <= LTUCLKDIVSET;
      cnt <= '0;
    end else begin
      cnt <= cnt + 3'd1;
    end
  end

  // Tick is held low for the whole reset window, including mid-period
  // assertion, without waiting for a clock edge.
  always_comb begin
    LTUCLKDIVGET = act;
    ltu_tick     = at_tc & ~reset;
  end

endmodule

// File: tb/tb_ltu_clk_div.sv
// Directed bench for ltu_clk_div: per-cycle vector table plus hand-written
// sequences for SET glitching and asynchronous mid-period reset.
module tb_ltu_clk_div;

  logic       clk;
  logic       reset;
  logic [1:0] set;
  logic [1:0] get;
  logic       tick;

  int checks;
  int failures;

  ltu_clk_div dut (
    .clk          (clk),
    .reset        (reset),
    .LTUCLKDIVSET (set),
    .LTUCLKDIVGET (get),
    .ltu_tick     (tick)
  );

  initial clk = 1'b0;
  always #8 clk = ~clk;

  typedef struct {
    logic [1:0] set;
    logic [1:0] get;
    logic       tick;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [1:0] s, input logic [1:0] g, input logic t);
    vec_t v;
    v.set  = s;
    v.get  = g;
    v.tick = t;
    vecs.push_back(v);
  endfunction

  task automatic check_out(input string name, input logic [1:0] eg, input logic et);
    checks++;
    if (get !== eg || tick !== et) begin
      failures++;
      $display("FAIL %s: got get=%0d tick=%0b, want get=%0d tick=%0b",
               name, get, tick, eg, et);
    end
  endtask

  // Drive SET before the next rising edge, then sample on the falling edge.
  task automatic step(input logic [1:0] s);
    set = s;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    set      = 2'd0;

    // N=1, then 0->1, then 1->2 with SET=3 requested mid-period, then a
    // change to 0 requested at cnt=2 of an 8-cycle period.
    for (int i = 0; i < 3; i++) add(2'd0, 2'd0, 1'b1);
    add(2'd1, 2'd1, 1'b0);
    add(2'd1, 2'd1, 1'b1);
    add(2'd1, 2'd1, 1'b0);
    add(2'd1, 2'd1, 1'b1);
    add(2'd2, 2'd2, 1'b0);
    add(2'd3, 2'd2, 1'b0);
    add(2'd3, 2'd2, 1'b0);
    add(2'd3, 2'd2, 1'b1);
    add(2'd3, 2'd3, 1'b0);
    add(2'd3, 2'd3, 1'b0);
    add(2'd3, 2'd3, 1'b0);
    for (int i = 0; i < 4; i++) add(2'd0, 2'd3, 1'b0);
    add(2'd0, 2'd3, 1'b1);
    add(2'd0, 2'd0, 1'b1);
    add(2'd0, 2'd0, 1'b1);

    #50;
    check_out("reset_hold", 2'd0, 1'b0);
    #50;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_out("reset_release", 2'd0, 1'b1);

    foreach (vecs[i]) begin
      step(vecs[i].set);
      check_out($sformatf("vec%0d", i), vecs[i].get, vecs[i].tick);
    end

    // SET glitching inside one 8-cycle period: only the value at the
    // closing tick edge (1) is adopted.
    step(2'd3);
    check_out("glitch_enter3", 2'd3, 1'b0);
    begin
      logic [1:0] seq [7];
      seq = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd1, 2'd1};
      for (int i = 0; i < 7; i++) begin
        step(seq[i]);
        check_out($sformatf("glitch_cnt%0d", i + 1), 2'd3, (i == 6));
      end
    end
    step(2'd1);
    check_out("glitch_applied", 2'd1, 1'b0);
    step(2'd1);
    check_out("glitch_ratio2", 2'd1, 1'b1);

    // Run to act=3, cnt=5, then reset asynchronously between edges.
    step(2'd3);
    check_out("pre_rst_act3", 2'd3, 1'b0);
    for (int i = 0; i < 5; i++) step(2'd3);
    check_out("pre_rst_cnt5", 2'd3, 1'b0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_out("async_reset", 2'd0, 1'b0);
    set = 2'd0;
    @(negedge clk);
    check_out("reset_held", 2'd0, 1'b0);
    reset = 1'b0;
    #1;
    check_out("rerelease", 2'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(2'd0);
      check_out($sformatf("post_rst%0d", i), 2'd0, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
